// File: rtl/decoupled_seq_checker.sv
// Reader for the decoupled FIFO port: pops io_count words and checks them against seed, seed+1, ...
// Ready follows enable by ARM_CYCLES and is registered, so no word past io_count is popped.
module decoupled_seq_checker #(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 16,
    parameter int ERR_W      = 16,
    parameter int ARM_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic             io_clock,
    input  logic             io_reset_n,
    input  logic             io_start,
    input  logic             io_abort,
    input  logic [CNT_W-1:0] io_count,
    input  logic [WIDTH-1:0] io_seed,
    input  logic [3:0]       io_throttle,
    output logic             io_rd_enable,
    output logic             io_rd_ready,
    input  logic             io_rd_valid,
    input  logic [WIDTH-1:0] io_rd_bits,
    output logic             io_busy,
    output logic             io_done,
    output logic             io_pass,
    output logic             io_timeout,
    output logic [ERR_W-1:0] io_err_count,
    output logic [CNT_W-1:0] io_rcv_count,
    output logic [CNT_W-1:0] io_first_err_index,
    output logic [WIDTH-1:0] io_first_err_bits
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int IDL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'((ARM_CYCLES > 0) ? ARM_CYCLES - 1 : 0);
    localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]       r_state;
    logic [ARM_W-1:0] r_arm_cnt;
    logic [IDL_W-1:0] r_idle_cnt;
    logic [3:0]       r_thr_cnt;
    logic [3:0]       r_throttle;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_expected;
    logic             r_enable;
    logic             r_ready;
    logic             r_timeout;
    logic [ERR_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_rcv_cnt;
    logic [CNT_W-1:0] r_ferr_idx;
    logic [WIDTH-1:0] r_ferr_bits;

    logic w_xfer;
    logic w_mismatch;
    logic w_last;

    assign w_xfer     = (r_state == S_RUN) && r_ready && io_rd_valid;
    assign w_mismatch = (io_rd_bits != r_expected);
    assign w_last     = (r_rcv_cnt == r_count - CNT_W'(1));

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            r_state     <= S_IDLE;
            r_arm_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_thr_cnt   <= '0;
            r_throttle  <= '0;
            r_count     <= '0;
            r_expected  <= '0;
            r_enable    <= 1'b0;
            r_ready     <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_cnt   <= '0;
            r_rcv_cnt   <= '0;
            r_ferr_idx  <= '0;
            r_ferr_bits <= '0;
        end else if (io_abort) begin
            // results stay frozen so the aborted run can still be inspected
            r_state  <= S_IDLE;
            r_enable <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (io_start) begin
                        r_count     <= io_count;
                        r_throttle  <= io_throttle;
                        r_expected  <= io_seed;
                        r_err_cnt   <= '0;
                        r_rcv_cnt   <= '0;
                        r_ferr_idx  <= '0;
                        r_ferr_bits <= '0;
                        r_timeout   <= 1'b0;
                        r_arm_cnt   <= '0;
                        if (io_count != '0) begin
                            r_state  <= S_ARM;
                            r_enable <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ARM: begin
                    if (r_arm_cnt == ARM_LAST) begin
                        r_state    <= S_RUN;
                        r_ready    <= 1'b1;
                        r_thr_cnt  <= '0;
                        r_idle_cnt <= '0;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
                    end
                end
                S_RUN: begin
                    // throttle counts RUN cycles, not transfers
                    if (r_throttle == 4'd0) begin
                        r_ready <= 1'b1;
                    end else if (!r_ready) begin
                        r_ready   <= 1'b1;
                        r_thr_cnt <= '0;
                    end else if (r_thr_cnt == r_throttle - 4'd1) begin
                        r_ready <= 1'b0;
                    end else begin
                        r_thr_cnt <= r_thr_cnt + 4'd1;
                    end

                    if (w_xfer) begin
                        if (w_mismatch) begin
                            if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_W'(1);
                            if (r_err_cnt == '0) begin
                                r_ferr_idx  <= r_rcv_cnt;
                                r_ferr_bits <= io_rd_bits;
                            end
                        end
                        r_expected <= r_expected + WIDTH'(1);
                        r_rcv_cnt  <= r_rcv_cnt + CNT_W'(1);
                        r_idle_cnt <= '0;
                        if (w_last) begin
                            r_state  <= S_DONE;
                            r_enable <= 1'b0;
                            r_ready  <= 1'b0;
                        end
                    end else if ((TIMEOUT != 0) && (r_idle_cnt == IDL_LAST)) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                        r_enable  <= 1'b0;
                        r_ready   <= 1'b0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IDL_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_rd_enable       = r_enable;
    assign io_rd_ready        = r_ready;
    assign io_busy            = (r_state == S_ARM) || (r_state == S_RUN);
    assign io_done            = (r_state == S_DONE);
    assign io_pass            = (r_state == S_DONE) && (r_err_cnt == '0) && !r_timeout;
    assign io_timeout         = r_timeout;
    assign io_err_count       = r_err_cnt;
    assign io_rcv_count       = r_rcv_cnt;
    assign io_first_err_index = r_ferr_idx;
    assign io_first_err_bits  = r_ferr_bits;

endmodule

// File: tb/tb_decoupled_seq_checker.sv
// Bench for decoupled_seq_checker: queue-based FIFO model on the read port, per-run
// expected results from a reference model, checked by a monitor when io_done rises.
module tb_decoupled_seq_checker;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int ERR_W = 16;
    localparam int ARM   = 2;
    localparam int TMO   = 1024;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             io_start = 1'b0;
    logic             io_abort = 1'b0;
    logic [CNT_W-1:0] io_count = '0;
    logic [WIDTH-1:0] io_seed = '0;
    logic [3:0]       io_throttle = '0;
    logic             rd_enable, rd_ready;
    logic             rd_valid = 1'b0;
    logic [WIDTH-1:0] rd_bits = '0;
    logic             busy, done, pass, tmo;
    logic [ERR_W-1:0] err_count;
    logic [CNT_W-1:0] rcv_count, ferr_idx;
    logic [WIDTH-1:0] ferr_bits;

    always #5 clk = ~clk;

    decoupled_seq_checker #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .ERR_W(ERR_W), .ARM_CYCLES(ARM), .TIMEOUT(TMO)
    ) dut (
        .io_clock(clk), .io_reset_n(rst_n), .io_start(io_start), .io_abort(io_abort),
        .io_count(io_count), .io_seed(io_seed), .io_throttle(io_throttle),
        .io_rd_enable(rd_enable), .io_rd_ready(rd_ready), .io_rd_valid(rd_valid),
        .io_rd_bits(rd_bits), .io_busy(busy), .io_done(done), .io_pass(pass),
        .io_timeout(tmo), .io_err_count(err_count), .io_rcv_count(rcv_count),
        .io_first_err_index(ferr_idx), .io_first_err_bits(ferr_bits)
    );

    typedef struct {
        longint err;
        longint rcv;
        longint fidx;
        longint fbits;
        longint pass;
        longint tmo;
        longint left;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fifo_q[$];
    bit          bubbles = 0;
    int          cur_thr = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    // FIFO read side: pop on handshake, present head at the falling edge
    always @(posedge clk) begin
        if (rd_valid && rd_ready && fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    always @(negedge clk) begin
        rd_valid = (fifo_q.size() > 0) && !(bubbles && $urandom_range(0, 3) == 0);
        rd_bits  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // Monitor: arm length, ready pattern, and end-of-run results
    bit prev_done = 0, prev_en = 0, arming = 0, running = 0;
    int arm_len = 0, k = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rd_enable && !prev_en) begin
            arming  = 1;
            arm_len = 0;
        end
        if (arming) begin
            if (!rd_enable) arming = 0;
            else if (rd_ready) begin
                check("arm_cycles_before_ready", arm_len, ARM);
                arming  = 0;
                running = 1;
                k       = 0;
            end else arm_len++;
        end
        if (running) begin
            if (!busy) running = 0;
            else begin
                check("ready_pattern", rd_ready, (cur_thr == 0) || (k % (cur_thr + 1) != cur_thr));
                k++;
            end
        end
        if (done && !prev_done) begin
            if (sb.size() == 0) check("unexpected_done", done, 0);
            else begin
                e = sb.pop_front();
                check("err_count", err_count, e.err);
                check("rcv_count", rcv_count, e.rcv);
                check("first_err_index", ferr_idx, e.fidx);
                check("first_err_bits", ferr_bits, e.fbits);
                check("pass", pass, e.pass);
                check("timeout", tmo, e.tmo);
                check("ready_low_in_done", rd_ready, 0);
                check("enable_low_in_done", rd_enable, 0);
                check("fifo_words_left", fifo_q.size(), e.left);
            end
        end
        prev_done = done;
        prev_en   = rd_enable;
    end

    task automatic pulse_abort();
        io_abort = 1'b1;
        @(negedge clk);
        io_abort = 1'b0;
    endtask

    task automatic run_case(input int cnt, input logic [31:0] seed, input int thr,
                            input logic [31:0] words[$], input bit bub);
        exp_t e;
        int   n;
        @(negedge clk);
        if (cnt == 0) pulse_abort();
        fifo_q  = words;
        bubbles = bub;
        n       = (cnt < words.size()) ? cnt : words.size();
        e.err = 0; e.fidx = 0; e.fbits = 0; e.rcv = n;
        for (int i = 0; i < n; i++) begin
            logic [31:0] want;
            want = seed + 32'(i);
            if (words[i] != want) begin
                if (e.err == 0) begin
                    e.fidx  = i;
                    e.fbits = words[i];
                end
                e.err++;
            end
        end
        if (e.err > 65535) e.err = 65535;
        e.tmo  = (words.size() < cnt);
        e.pass = (e.err == 0) && !e.tmo;
        e.left = words.size() - n;
        sb.push_back(e);
        io_count    = CNT_W'(cnt);
        io_seed     = seed;
        io_throttle = 4'(thr);
        cur_thr     = thr;
        io_start    = 1'b1;
        @(negedge clk);
        io_start = 1'b0;
        for (int c = 0; c < 8 * cnt + 2000; c++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("run_completed", sb.size(), 0);
        if (sb.size() != 0) begin
            sb.delete();
            pulse_abort();
        end
    endtask

    initial begin
        logic [31:0] w[$];
        int          cnt, len, thr;
        logic [31:0] seed;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle after reset
        repeat (15) @(negedge clk);
        check("idle_rd_enable", rd_enable, 0);
        check("idle_rd_ready", rd_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_rcv_count", rcv_count, 0);
        check("idle_err_count", err_count, 0);

        // long clean run
        w.delete();
        for (int i = 0; i < 1027; i++) w.push_back(32'(i));
        run_case(1027, 32'd0, 0, w, 0);

        // single corrupted word
        w.delete();
        for (int i = 0; i < 10; i++) w.push_back(32'(i));
        w[4] = 32'hDEAD;
        run_case(10, 32'd0, 0, w, 0);

        // empty FIFO times out
        w.delete();
        run_case(5, 32'h1234, 0, w, 0);

        // throttled with data wrapping through zero
        w.delete();
        for (int i = 0; i < 12; i++) w.push_back(32'hFFFF_FFFE + 32'(i));
        run_case(12, 32'hFFFF_FFFE, 3, w, 0);

        // randomized back-to-back runs
        for (int r = 0; r < 12; r++) begin
            cnt  = (r == 3) ? 0 : $urandom_range(1, 40);
            seed = $urandom;
            thr  = $urandom_range(0, 15);
            len  = (r == 6) ? cnt - $urandom_range(1, cnt) : cnt + $urandom_range(0, 3);
            w.delete();
            for (int i = 0; i < len; i++) begin
                logic [31:0] v;
                v = seed + 32'(i);
                if ($urandom_range(0, 7) == 0) v = v ^ (32'($urandom_range(1, 255)) << $urandom_range(0, 24));
                w.push_back(v);
            end
            run_case(cnt, seed, thr, w, 1'($urandom_range(0, 1)));
        end

        // abort mid-run
        @(negedge clk);
        fifo_q.delete();
        for (int i = 0; i < 20; i++) fifo_q.push_back(32'(i));
        bubbles  = 0;
        io_count = 16'd20; io_seed = '0; io_throttle = '0; cur_thr = 0;
        io_start = 1'b1;
        @(negedge clk);
        io_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rcv_count == 7) break;
            @(negedge clk);
        end
        check("abort_reached_7", rcv_count, 7);
        pulse_abort();
        check("abort_busy", busy, 0);
        check("abort_rd_enable", rd_enable, 0);
        check("abort_rd_ready", rd_ready, 0);
        check("abort_done", done, 0);
        check("abort_rcv_held", rcv_count, 7);

        // asynchronous reset in the middle of a run with an error already logged
        fifo_q.delete();
        for (int i = 0; i < 20; i++) fifo_q.push_back((i == 1) ? 32'hBAD : 32'(i));
        io_start = 1'b1;
        @(negedge clk);
        io_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rcv_count >= 3) break;
            @(negedge clk);
        end
        check("pre_reset_err_count", err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rd_enable", rd_enable, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", tmo, 0);
        check("rst_err_count", err_count, 0);
        check("rst_rcv_count", rcv_count, 0);
        check("rst_first_err_index", ferr_idx, 0);
        check("rst_first_err_bits", ferr_bits, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
